cam_rgb565_capture: RTL and testbench
=====================================

// Module: cam_rgb565_capture
// PURPOSE
//  Upstream capture stage for Sobel_Filter: samples OV7670-style 8-bit camera bus (VSYNC/HREF/D[7:0]),
//  packs byte pairs into RGB565 pixels and emits the we/wAddr/wData write stream the filter and frame
//  buffer consume. Frame-synchronised: capture starts only on a clean frame boundary, never mid-frame.
//  Out-of-range pixels are clipped so the address never leaves the IMG_WIDTH x IMG_HEIGHT buffer.
// PARAMETERS
//  IMG_WIDTH   320  pixels per line written; excess pixels in a line are dropped
//  IMG_HEIGHT  240  lines per frame written; excess lines dropped, ovf_err set
//  ADDR_W      17   width of wAddr_out; must satisfy 2**ADDR_W >= IMG_WIDTH*IMG_HEIGHT
// PORTS
//  clk         in   1       camera PCLK domain clock; all inputs sampled on rising edge
//  reset       in   1       synchronous, active-low reset
//  cap_en      in   1       level: 1 = arm/continue capture, 0 = stop after current frame
//  cam_vsync   in   1       high during vertical blank
//  cam_href    in   1       high while line bytes are valid
//  cam_data    in   8       camera byte, first byte of pair = RGB565[15:8], second = [7:0]
//  we_out      out  1       1-cycle write strobe per pixel
//  wAddr_out   out  ADDR_W  pixel address = row*IMG_WIDTH + col
//  wData_out   out  16      RGB565 pixel {R5,G6,B5}
//  frame_done  out  1       1-cycle pulse at end of each captured frame
//  busy        out  1       1 while state != IDLE
//  ovf_err     out  1       sticky: frame had > IMG_HEIGHT lines or > IMG_WIDTH pixels in a line
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE; we_out, wAddr_out, wData_out, frame_done, busy, ovf_err = 0;
//    counters/phase/edge registers cleared. Reset mid-frame aborts immediately; no further writes that frame.
//  - Edge detect: vsync_q/href_q registered copies; rise/fall = current vs _q.
//  - FSM: IDLE -> WAIT_VS when cap_en=1. WAIT_VS -> CAPTURE on vsync fall (1->0); a frame already in
//    progress when armed is skipped. CAPTURE -> on vsync rise: frame_done=1 next cycle, go WAIT_VS if
//    cap_en=1 else IDLE. cap_en=0 during CAPTURE does not truncate the frame.
//  - Byte pairing: in CAPTURE while href=1, phase toggles each cycle; phase0 latches hi byte, phase1 forms
//    pixel {hi,cam_data}. we_out=1 in the cycle after phase1 sample (latency 1), with wData/wAddr valid same cycle.
//  - Addressing: no multiplier. col counter, line_base register (+=IMG_WIDTH per line), wAddr=line_base+col.
//    href fall: row++, col=0, phase=0; an unpaired hi byte at href fall is discarded silently.
//  - Clipping: col>=IMG_WIDTH or row>=IMG_HEIGHT -> pixel not written (we_out stays 0), ovf_err<=1.
//    ovf_err clears only on reset or on entry to CAPTURE.
//  - vsync rise while href=1: line terminated, pending half-pixel dropped, frame_done still pulses.
//  - we_out and frame_done never high in the same cycle; wAddr/wData hold last value when we_out=0.
// CONFIGURATION
//  CAM_TESTPAT_EN  defined: adds input testpat (1 bit). When testpat=1 the sensor byte values are ignored but
//    timing still comes from VSYNC/HREF; wData_out = {(row+col)%32, (row*2)%64, (col*3)%32} (R,G,B),
//    the gradient used to characterise Sobel_Filter. Undefined: port absent, data always from cam_data.
// TESTING (bench with IMG_WIDTH=8, IMG_HEIGHT=8, model drives vsync/href/data)
//  1 Reset: hold reset=0 3 cycles with href toggling -> all outputs 0, busy=0, no we_out.
//  2 Nominal frame: cap_en=1, vsync pulse, 8 lines x 16 bytes, byte k=k -> 64 writes, addr 0..63,
//    first wData=16'h0001, second 16'h0203; we_out 1 cycle after each 2nd byte; frame_done 1 pulse after vsync rise.
//  3 Arm mid-frame: cap_en raised during line 3 -> no writes until next vsync fall, then full frame addr 0..63.
//  4 Overflow: 10 lines x 20 bytes -> exactly 64 writes, max addr 63, ovf_err=1 after frame; cleared at next capture.
//  5 Odd line + early vsync: line of 15 bytes -> 7 writes, col resets; vsync rise mid-line -> no write, frame_done pulses.
//  6 CAM_TESTPAT_EN, testpat=1: row 2 col 3 -> wAddr=19, wData={5'd5,6'd4,5'd9}=16'h2889; cap_en=0 mid-frame -> frame completes, then IDLE.

Source files
------------

// File: rtl/cam_rgb565_capture.sv
// cam_rgb565_capture
// Capture stage for an OV7670-style 8-bit camera bus. Byte pairs become
// RGB565 pixels, which are sent out as a we/wAddr/wData write stream for a
// frame buffer of IMG_WIDTH x IMG_HEIGHT pixels.
// Capture only begins on a clean frame boundary (a VSYNC falling edge).
// Pixels outside the buffer are clipped, and ovf_err records that this happened.
// Optional feature: define CAM_TESTPAT_EN to add a 'testpat' input. When it is
// set, the pixel data becomes a row/column gradient and cam_data is ignored.
module cam_rgb565_capture #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_en,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
`ifdef CAM_TESTPAT_EN
  input  logic              testpat,
`endif
  output logic              we_out,
  output logic [ADDR_W-1:0] wAddr_out,
  output logic [15:0]       wData_out,
  output logic              frame_done,
  output logic              busy,
  output logic              ovf_err
);

  // The counters can go one past the last valid index. This lets them
  // saturate at "out of range" and never wrap back into the buffer.
  localparam int COL_W = $clog2(IMG_WIDTH + 1);
  localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(IMG_WIDTH);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(IMG_HEIGHT);
  localparam logic [ADDR_W-1:0] LINE_INC = ADDR_W'(IMG_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_CAPTURE
  } state_t;

  state_t             state_q;
  logic               vsync_q;
  logic               href_q;
  logic               phase_q;
  logic [7:0]         hi_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [ADDR_W-1:0]  line_base_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [15:0]        data_q;
  logic               fd_q;
  logic               ovf_q;

  logic               vs_rise;
  logic               vs_fall;
  logic               href_fall;
  logic               in_range_d;
  logic [ADDR_W-1:0]  pix_addr_d;
  logic [15:0]        pix_data_d;

`ifdef CAM_TESTPAT_EN
  logic [15:0]        row_x;
  logic [15:0]        col_x;
`endif

  assign vs_rise   =  cam_vsync & ~vsync_q;
  assign vs_fall   = ~cam_vsync &  vsync_q;
  assign href_fall = ~cam_href  &  href_q;

  // Candidate pixel for the current cycle. The address is built from the
  // line base plus the column, so no multiplier is needed.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    in_range_d = (col_q < COL_MAX) && (row_q < ROW_MAX);
    pix_addr_d = line_base_q + ADDR_W'(col_q);
    pix_data_d = {hi_q, cam_data};
`ifdef CAM_TESTPAT_EN
    row_x = 16'(row_q);
    col_x = 16'(col_q);
    if (testpat) begin
      pix_data_d = {5'(row_x + col_x), 6'(row_x << 1), 5'(col_x + (col_x << 1))};
    end
`endif
  end

  // Frame FSM, byte pairing, counters and registered write-port outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
    if (!reset) begin
      state_q     <= ST_IDLE;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      phase_q     <= 1'b0;
      hi_q        <= 8'h00;
      col_q       <= '0;
      row_q       <= '0;
      line_base_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= 16'h0000;
      fd_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      vsync_q <= cam_vsync;
      href_q  <= cam_href;
      we_q    <= 1'b0;
      fd_q    <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (cap_en) state_q <= ST_WAIT_VS;
        end

        ST_WAIT_VS: begin
          if (!cap_en) begin
            state_q <= ST_IDLE;
          end else if (vs_fall) begin
            state_q     <= ST_CAPTURE;
            phase_q     <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            line_base_q <= '0;
            ovf_q       <= 1'b0;
          end
        end

        ST_CAPTURE: begin
          if (vs_rise) begin
            // End of frame. A half-pixel that is still pending is dropped.
            fd_q    <= 1'b1;
            phase_q <= 1'b0;
            state_q <= cap_en ? ST_WAIT_VS : ST_IDLE;
          end else if (href_fall) begin
            // End of line. A pending unpaired high byte is discarded.
            phase_q <= 1'b0;
            col_q   <= '0;
            if (row_q < ROW_MAX) begin
              row_q       <= row_q + ROW_W'(1);
              line_base_q <= line_base_q + LINE_INC;
            end
          end else if (cam_href) begin
            if (!phase_q) begin
              hi_q    <= cam_data;
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (in_range_d) begin
                we_q   <= 1'b1;
                addr_q <= pix_addr_d;
                data_q <= pix_data_d;
              end else begin
                ovf_q <= 1'b1;
              end
              if (col_q < COL_MAX) col_q <= col_q + COL_W'(1);
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign we_out     = we_q;
  assign wAddr_out  = addr_q;
  assign wData_out  = data_q;
  assign frame_done = fd_q;
  assign busy       = (state_q != ST_IDLE);
  assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_cam_rgb565_capture.sv
// Directed bench for cam_rgb565_capture using an 8x8 frame buffer.
// The camera bus is driven one byte per cycle. Writes and frame_done pulses
// are logged as they occur, and each scenario task compares them against
// expected values computed by hand.
module tb_cam_rgb565_capture;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cap_en;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;
`ifdef CAM_TESTPAT_EN
  logic          testpat;
`endif
  logic          we_out;
  logic [AW-1:0] wAddr_out;
  logic [15:0]   wData_out;
  logic          frame_done;
  logic          busy;
  logic          ovf_err;

  int n_checks = 0;
  int n_errors = 0;

  int            wr_cnt = 0;
  int            fd_cnt = 0;
  int            overlap_cnt = 0;
  logic [AW-1:0] max_addr = '0;
  logic [AW-1:0] log_addr [0:255];
  logic [15:0]   log_data [0:255];

  logic fd_at_rise;
  logic fd_after_rise;
  logic lat_we0;
  logic lat_we1;

  cam_rgb565_capture #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_W    (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cap_en    (cap_en),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
`ifdef CAM_TESTPAT_EN
    .testpat   (testpat),
`endif
    .we_out    (we_out),
    .wAddr_out (wAddr_out),
    .wData_out (wData_out),
    .frame_done(frame_done),
    .busy      (busy),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  // Write/frame_done logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (we_out === 1'b1) begin
      if (wr_cnt < 256) begin
        log_addr[wr_cnt] = wAddr_out;
        log_data[wr_cnt] = wData_out;
      end
      if (wAddr_out > max_addr) max_addr = wAddr_out;
      wr_cnt++;
    end
    if (frame_done === 1'b1) fd_cnt++;
    if (we_out === 1'b1 && frame_done === 1'b1) overlap_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one bus cycle at the falling edge, then wait until the next
  // falling edge so the outputs reflect that sample.
  task automatic tick(input logic vs, input logic hs, input logic [7:0] d);
    cam_vsync = vs;
    cam_href  = hs;
    cam_data  = d;
    @(negedge clk);
  endtask

  task automatic clear_log();
    wr_cnt   = 0;
    fd_cnt   = 0;
    max_addr = '0;
  endtask

  // One frame: a VSYNC pulse, then 'lines' lines of 'bpl' bytes each with
  // byte k = k, then a VSYNC rise. The optional line indices mark where
  // cap_en is raised, where it is dropped, and where reset is pulsed.
  task automatic send_frame(input int lines, input int bpl, input int arm_line,
                            input int stop_line, input int rst_line);
    int k;
    k = 0;
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    repeat (3) tick(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < lines; l++) begin
      if (l == arm_line)  cap_en = 1'b1;
      if (l == stop_line) cap_en = 1'b0;
      if (l == rst_line) begin
        reset = 1'b0;
        repeat (2) tick(1'b0, 1'b0, 8'h00);
        reset = 1'b1;
      end
      for (int b = 0; b < bpl; b++) begin
        tick(1'b0, 1'b1, 8'(k));
        if (l == 0 && b == 0) lat_we0 = we_out;
        if (l == 0 && b == 1) lat_we1 = we_out;
        k++;
      end
      repeat (2) tick(1'b0, 1'b0, 8'h00);
    end
    tick(1'b1, 1'b0, 8'h00);
    fd_at_rise = frame_done;
    tick(1'b1, 1'b0, 8'h00);
    fd_after_rise = frame_done;
    repeat (2) tick(1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    cap_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, (i % 2) == 0, 8'hA5);
      n_checks++;
      if ({we_out, wAddr_out, wData_out, frame_done, busy, ovf_err} !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs cycle %0d: got we=%b addr=%h data=%h fd=%b busy=%b ovf=%b, want all 0",
                 i, we_out, wAddr_out, wData_out, frame_done, busy, ovf_err);
      end
    end
    reset = 1'b1;
    tick(1'b1, 1'b0, 8'h00);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_busy: got %b want 1", busy);
    end
  endtask

  task automatic test_nominal();
    clear_log();
    cap_en = 1'b1;
    send_frame(8, 16, -1, -1, -1);
    n_checks++;
    if (wr_cnt != 64) begin
      n_errors++;
      $display("FAIL nominal_writes: got %0d want 64", wr_cnt);
    end
    n_checks++;
    if (lat_we0 !== 1'b0 || lat_we1 !== 1'b1) begin
      n_errors++;
      $display("FAIL nominal_latency: we after byte0=%b byte1=%b, want 0 then 1", lat_we0, lat_we1);
    end
    n_checks++;
    if (log_data[0] !== 16'h0001 || log_data[1] !== 16'h0203) begin
      n_errors++;
      $display("FAIL nominal_first_data: got %h %h want 0001 0203", log_data[0], log_data[1]);
    end
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (log_addr[i] !== AW'(i) || log_data[i] !== {8'(2 * i), 8'(2 * i + 1)}) begin
        n_errors++;
        $display("FAIL nominal_pixel %0d: got addr=%0d data=%h want addr=%0d data=%h",
                 i, log_addr[i], log_data[i], i, {8'(2 * i), 8'(2 * i + 1)});
      end
    end
    n_checks++;
    if (fd_at_rise !== 1'b1 || fd_after_rise !== 1'b0 || fd_cnt != 1) begin
      n_errors++;
      $display("FAIL nominal_frame_done: got at_rise=%b next=%b count=%0d want 1 0 1",
               fd_at_rise, fd_after_rise, fd_cnt);
    end
    n_checks++;
    if (ovf_err !== 1'b0) begin
      n_errors++;
      $display("FAIL nominal_ovf: got %b want 0", ovf_err);
    end
  endtask

  task automatic test_arm_mid_frame();
    cap_en = 1'b0;
    repeat (2) tick(1'b1, 1'b0, 8'h00);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL arm_idle_busy: got %b want 0", busy);
    end
    clear_log();
    send_frame(8, 16, 3, -1, -1);
    n_checks++;
    if (wr_cnt != 0 || fd_cnt != 0) begin
      n_errors++;
      $display("FAIL arm_skipped_frame: got writes=%0d fd=%0d want 0 0", wr_cnt, fd_cnt);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL arm_waiting_busy: got %b want 1", busy);
    end
    clear_log();
    send_frame(8, 16, -1, -1, -1);
    n_checks++;
    if (wr_cnt != 64 || log_addr[0] !== 8'd0 || log_addr[63] !== 8'd63 || fd_cnt != 1) begin
      n_errors++;
      $display("FAIL arm_next_frame: got writes=%0d first=%0d last=%0d fd=%0d want 64 0 63 1",
               wr_cnt, log_addr[0], log_addr[63], fd_cnt);
    end
  endtask

  task automatic test_overflow();
    clear_log();
    cap_en = 1'b1;
    send_frame(10, 20, -1, -1, -1);
    n_checks++;
    if (wr_cnt != 64 || max_addr !== 8'd63) begin
      n_errors++;
      $display("FAIL ovf_writes: got writes=%0d max=%0d want 64 63", wr_cnt, max_addr);
    end
    n_checks++;
    if (log_addr[8] !== 8'd8 || log_data[8] !== 16'h1415) begin
      n_errors++;
      $display("FAIL ovf_row1_start: got addr=%0d data=%h want 8 1415", log_addr[8], log_data[8]);
    end
    n_checks++;
    if (log_data[63] !== 16'h9A9B) begin
      n_errors++;
      $display("FAIL ovf_last_data: got %h want 9a9b", log_data[63]);
    end
    n_checks++;
    if (ovf_err !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_sticky: got %b want 1", ovf_err);
    end
    clear_log();
    send_frame(8, 16, -1, -1, -1);
    n_checks++;
    if (ovf_err !== 1'b0 || wr_cnt != 64) begin
      n_errors++;
      $display("FAIL ovf_cleared: got ovf=%b writes=%0d want 0 64", ovf_err, wr_cnt);
    end
  endtask

  task automatic test_odd_line_early_vsync();
    int k;
    clear_log();
    cap_en = 1'b1;
    k = 0;
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    repeat (3) tick(1'b0, 1'b0, 8'h00);
    for (int b = 0; b < 15; b++) begin tick(1'b0, 1'b1, 8'(k)); k++; end
    repeat (2) tick(1'b0, 1'b0, 8'h00);
    for (int b = 0; b < 16; b++) begin tick(1'b0, 1'b1, 8'(k)); k++; end
    repeat (2) tick(1'b0, 1'b0, 8'h00);
    for (int b = 0; b < 5; b++) begin tick(1'b0, 1'b1, 8'(k)); k++; end
    tick(1'b1, 1'b1, 8'hEE);
    n_checks++;
    if (we_out !== 1'b0 || frame_done !== 1'b1) begin
      n_errors++;
      $display("FAIL early_vsync_cycle: got we=%b fd=%b want 0 1", we_out, frame_done);
    end
    tick(1'b1, 1'b0, 8'h00);
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_errors++;
      $display("FAIL early_vsync_fd_width: got %b want 0", frame_done);
    end
    repeat (2) tick(1'b1, 1'b0, 8'h00);
    n_checks++;
    if (wr_cnt != 17 || fd_cnt != 1) begin
      n_errors++;
      $display("FAIL odd_line_counts: got writes=%0d fd=%0d want 17 1", wr_cnt, fd_cnt);
    end
    n_checks++;
    if (log_addr[6] !== 8'd6 || log_addr[7] !== 8'd8 || log_data[7] !== 16'h0F10) begin
      n_errors++;
      $display("FAIL odd_line_col_reset: got a6=%0d a7=%0d d7=%h want 6 8 0f10",
               log_addr[6], log_addr[7], log_data[7]);
    end
    n_checks++;
    if (log_addr[16] !== 8'd17 || log_data[16] !== 16'h2122 || ovf_err !== 1'b0) begin
      n_errors++;
      $display("FAIL early_vsync_last_write: got addr=%0d data=%h ovf=%b want 17 2122 0",
               log_addr[16], log_data[16], ovf_err);
    end
  endtask

  task automatic test_stop_mid_frame();
    logic [15:0] exp19;
`ifdef CAM_TESTPAT_EN
    testpat = 1'b1;
    exp19   = 16'h2889;
`else
    exp19   = 16'h2627;
`endif
    clear_log();
    cap_en = 1'b1;
    send_frame(8, 16, -1, 4, -1);
    n_checks++;
    if (wr_cnt != 64 || fd_cnt != 1) begin
      n_errors++;
      $display("FAIL stop_frame_completes: got writes=%0d fd=%0d want 64 1", wr_cnt, fd_cnt);
    end
    n_checks++;
    if (log_addr[19] !== 8'd19 || log_data[19] !== exp19) begin
      n_errors++;
      $display("FAIL pixel_r2c3: got addr=%0d data=%h want 19 %h", log_addr[19], log_data[19], exp19);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL stop_idle: got busy=%b want 0", busy);
    end
`ifdef CAM_TESTPAT_EN
    testpat = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    cap_en = 1'b1;
    repeat (2) tick(1'b1, 1'b0, 8'h00);
    send_frame(8, 16, -1, -1, 2);
    n_checks++;
    if (wr_cnt != 16 || fd_cnt != 0) begin
      n_errors++;
      $display("FAIL reset_abort: got writes=%0d fd=%0d want 16 0", wr_cnt, fd_cnt);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_abort_rearm: got busy=%b want 1", busy);
    end
  endtask

  initial begin
    reset     = 1'b0;
    cap_en    = 1'b0;
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    cam_data  = 8'h00;
`ifdef CAM_TESTPAT_EN
    testpat   = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_nominal();
    test_arm_mid_frame();
    test_overflow();
    test_odd_line_early_vsync();
    test_stop_mid_frame();
    test_reset_mid_frame();
    n_checks++;
    if (overlap_cnt != 0) begin
      n_errors++;
      $display("FAIL we_fd_overlap: got %0d cycles want 0", overlap_cnt);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
